// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer between the imem req/ack port and decode.
// Optional PC_ALIGN_CHECK_EN: force-align misaligned redirect targets and flag a sticky addr_err.
module pc_sequencer #(
    parameter int              AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          branch,
    input  logic [AW-1:0] branch_pc,
    input  logic          jump,
    input  logic [AW-1:0] jump_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    output logic [AW-1:0] pc_plus4,
    output logic          addr_err
);

    // Handshakes: imem_req stays high with imem_addr stable until imem_ack is sampled;
    // instr/instr_pc/instr_valid hold while stall is high and are consumed on a cycle with stall low.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] redir_pc;
    logic          redir_pend;
    logic          redir_now;
    logic [AW-1:0] raw_tgt;
    logic [AW-1:0] tgt;

    assign redir_now = jump | branch;
    assign raw_tgt   = jump ? jump_pc : branch_pc;
    assign imem_addr = pc;
    assign pc_plus4  = instr_pc + AW'(4);

`ifdef PC_ALIGN_CHECK_EN
    assign tgt = {raw_tgt[AW-1:2], 2'b00};

    // Only redirects the FSM actually accepts can raise the error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (redir_now && (state != IDLE) && (raw_tgt[1:0] != 2'b00)) begin
            addr_err <= 1'b1;
        end
    end
`else
    assign tgt      = raw_tgt;
    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            redir_pend  <= 1'b0;
            redir_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end

                FETCH: begin
                    if (imem_ack) begin
                        if (redir_now) begin
                            // Stale data: refetch at the redirect, request stays up.
                            pc         <= tgt;
                            redir_pend <= 1'b0;
                        end else if (redir_pend) begin
                            pc         <= redir_pc;
                            redir_pend <= 1'b0;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            pc          <= pc + AW'(4);
                            instr_valid <= 1'b1;
                            imem_req    <= 1'b0;
                            state       <= VALID;
                        end
                    end else if (redir_now) begin
                        redir_pend <= 1'b1;
                        redir_pc   <= tgt;
                    end
                end

                VALID: begin
                    if (stall) begin
                        if (redir_now) begin
                            redir_pend <= 1'b1;
                            redir_pc   <= tgt;
                        end
                    end else begin
                        if (redir_now) begin
                            pc <= tgt;
                        end else if (redir_pend) begin
                            pc <= redir_pc;
                        end
                        redir_pend  <= 1'b0;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end

                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, reset/wrap sequences, and a randomized run
// checked against a delivery-level model of which PC decode should see next.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] ALIGN_ADDR = 32'h0000_0100;
  localparam logic        ERR_EXP    = 1'b1;
`else
  localparam logic [31:0] ALIGN_ADDR = 32'h0000_0103;
  localparam logic        ERR_EXP    = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic [31:0] branch_pc;
  logic        jump;
  logic [31:0] jump_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [31:0] pc_plus4;
  logic        addr_err;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  pc_sequencer #(.AW(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .branch_pc(branch_pc),
    .jump(jump), .jump_pc(jump_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .pc_plus4(pc_plus4), .addr_err(addr_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents are a fixed hash of the address so every fetched word is predictable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    stall = 1'b0; jump = 1'b0; branch = 1'b0; imem_ack = 1'b0;
    jump_pc = '0; branch_pc = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC;
    t = $urandom();
    t[1:0] = 2'b00;
    return t;
  endfunction

  typedef struct {
    logic        stall;
    logic        jump;
    logic [31:0] jump_pc;
    logic        branch;
    logic [31:0] branch_pc;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ipc;
    logic        exp_err;
  } vec_t;

  function automatic vec_t v(input logic s, input logic j, input logic [31:0] jp,
                             input logic b, input logic [31:0] bp, input logic a,
                             input logic er, input logic [31:0] ea, input logic ev,
                             input logic [31:0] ei, input logic ee);
    vec_t r;
    r.stall = s; r.jump = j; r.jump_pc = jp; r.branch = b; r.branch_pc = bp; r.ack = a;
    r.exp_req = er; r.exp_addr = ea; r.exp_valid = ev; r.exp_ipc = ei; r.exp_err = ee;
    return r;
  endfunction

  vec_t vecs[24];

  initial begin
    checks = 0;
    failures = 0;
    // Row i: inputs driven during cycle i, outputs expected during cycle i (cycle 0 = first after reset).
    vecs[0]  = v(0, 0, 0,     0, 0,     0,  0, 0,          0, 0,          0);
    vecs[1]  = v(0, 0, 0,     0, 0,     1,  1, 32'h0,      0, 0,          0);
    vecs[2]  = v(0, 0, 0,     0, 0,     0,  0, 0,          1, 32'h0,      0);
    vecs[3]  = v(0, 0, 0,     0, 0,     1,  1, 32'h4,      0, 0,          0);
    vecs[4]  = v(0, 0, 0,     0, 0,     0,  0, 0,          1, 32'h4,      0);
    vecs[5]  = v(0, 0, 0,     0, 0,     1,  1, 32'h8,      0, 0,          0);
    vecs[6]  = v(1, 0, 0,     0, 0,     0,  0, 0,          1, 32'h8,      0);
    vecs[7]  = v(1, 0, 0,     0, 0,     0,  0, 0,          1, 32'h8,      0);
    vecs[8]  = v(1, 0, 0,     0, 0,     0,  0, 0,          1, 32'h8,      0);
    vecs[9]  = v(0, 0, 0,     0, 0,     0,  0, 0,          1, 32'h8,      0);
    vecs[10] = v(0, 0, 0,     0, 0,     1,  1, 32'hC,      0, 0,          0);
    vecs[11] = v(0, 1, 32'h100, 1, 32'h200, 0, 0, 0,       1, 32'hC,      0);
    vecs[12] = v(0, 0, 0,     0, 0,     0,  1, 32'h100,    0, 0,          0);
    vecs[13] = v(0, 0, 0,     0, 0,     1,  1, 32'h100,    0, 0,          0);
    vecs[14] = v(0, 1, 32'h10, 0, 0,    0,  0, 0,          1, 32'h100,    0);
    vecs[15] = v(0, 0, 0,     1, 32'h40, 0, 1, 32'h10,     0, 0,          0);
    vecs[16] = v(0, 0, 0,     0, 0,     0,  1, 32'h10,     0, 0,          0);
    vecs[17] = v(0, 0, 0,     0, 0,     1,  1, 32'h10,     0, 0,          0);
    vecs[18] = v(0, 0, 0,     0, 0,     1,  1, 32'h40,     0, 0,          0);
    vecs[19] = v(0, 0, 0,     0, 0,     0,  0, 0,          1, 32'h40,     0);
    vecs[20] = v(0, 0, 0,     0, 0,     1,  1, 32'h44,     0, 0,          0);
    vecs[21] = v(0, 1, 32'h103, 0, 0,   0,  0, 0,          1, 32'h44,     0);
    vecs[22] = v(0, 0, 0,     0, 0,     1,  1, ALIGN_ADDR, 0, 0,          ERR_EXP);
    vecs[23] = v(0, 0, 0,     0, 0,     0,  0, 0,          1, ALIGN_ADDR, ERR_EXP);

    do_reset();
    chk("reset_instr", instr, 32'h0);
    chk("reset_instr_pc", instr_pc, 32'h0);
    chk("reset_addr", imem_addr, RESET_PC);

    for (int i = 0; i < 24; i++) begin
      stall = vecs[i].stall; jump = vecs[i].jump; jump_pc = vecs[i].jump_pc;
      branch = vecs[i].branch; branch_pc = vecs[i].branch_pc; imem_ack = vecs[i].ack;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_err", i), {31'b0, addr_err}, {31'b0, vecs[i].exp_err});
      if (vecs[i].exp_req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_ipc", i), instr_pc, vecs[i].exp_ipc);
        chk($sformatf("vec%0d_instr", i), instr, mem_word(vecs[i].exp_ipc));
        chk($sformatf("vec%0d_pc4", i), pc_plus4, vecs[i].exp_ipc + 32'd4);
      end
      next_cycle();
    end

    // Reset asserted while a fetch is outstanding, with an ack arriving during reset.
    drive_idle();
    chk("pre_reset_req", {31'b0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    chk("midrst_addr", imem_addr, RESET_PC);
    chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_ipc", instr_pc, 32'h0);
    chk("midrst_err", {31'b0, addr_err}, 32'd0);
    next_cycle();
    chk("inrst_req", {31'b0, imem_req}, 32'd0);
    chk("inrst_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_req", {31'b0, imem_req}, 32'd0);
    next_cycle();
    imem_ack = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, RESET_PC);

    // Redirect to the top word and check the PC wraps to 0.
    next_cycle();
    imem_ack = 1'b0; jump = 1'b1; jump_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("wrap_first_valid", {31'b0, instr_valid}, 32'd1);
    chk("wrap_first_ipc", instr_pc, RESET_PC);
    next_cycle();
    jump = 1'b0; imem_ack = 1'b1;
    @(negedge clk);
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    imem_ack = 1'b0;
    @(negedge clk);
    chk("wrap_top_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_top_instr", instr, mem_word(32'hFFFF_FFFC));
    chk("wrap_pc4", pc_plus4, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("wrap_next_req", {31'b0, imem_req}, 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0);

    run_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Model: the next delivered PC is the last redirect target seen since the previous
  // delivery, otherwise the previous delivered PC + 4.
  task automatic run_random();
    logic [31:0] exp_next;
    logic [31:0] exp_pc;
    logic        valid_prev, req_prev, ack_prev, stall_prev;
    logic [31:0] addr_prev, ipc_prev, instr_prev;
    int          since;
    int          deliveries;
    do_reset();
    exp_next = RESET_PC;
    valid_prev = 1'b0; req_prev = 1'b0; ack_prev = 1'b0; stall_prev = 1'b0;
    addr_prev = '0; ipc_prev = '0; instr_prev = '0;
    since = 0;
    deliveries = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stall = ($urandom_range(0, 9) < 4);
      jump_pc = rand_tgt();
      branch_pc = rand_tgt();
      if (cyc > 0 && $urandom_range(0, 9) == 0) begin
        jump = 1'($urandom_range(0, 1));
        branch = jump ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        jump = 1'b0;
        branch = 1'b0;
      end
      imem_ack = imem_req && ($urandom_range(0, 2) != 0);
      @(negedge clk);
      chk("rnd_req_valid_excl", {31'b0, imem_req & instr_valid}, 32'd0);
      if (instr_valid && !valid_prev) begin
        exp_q.push_back(exp_next);
        exp_pc = exp_q.pop_front();
        chk("rnd_ipc", instr_pc, exp_pc);
        chk("rnd_instr", instr, mem_word(exp_pc));
        chk("rnd_pc4", pc_plus4, exp_pc + 32'd4);
        exp_next = exp_pc + 32'd4;
        since = 0;
        deliveries++;
      end
      if (valid_prev && instr_valid) begin
        chk("rnd_hold_stall", {31'b0, stall_prev}, 32'd1);
        chk("rnd_hold_ipc", instr_pc, ipc_prev);
        chk("rnd_hold_instr", instr, instr_prev);
      end
      if (valid_prev && !stall_prev) chk("rnd_consume_req", {31'b0, imem_req}, 32'd1);
      if (req_prev && imem_req && !ack_prev) chk("rnd_addr_stable", imem_addr, addr_prev);
      since++;
      if (since > 80) begin
        chk("rnd_delivery_timeout", 32'(since), 32'd0);
        break;
      end
      if (jump) exp_next = jump_pc;
      else if (branch) exp_next = branch_pc;
      valid_prev = instr_valid; req_prev = imem_req; ack_prev = imem_ack; stall_prev = stall;
      addr_prev = imem_addr; ipc_prev = instr_pc; instr_prev = instr;
      next_cycle();
    end
    chk("rnd_deliveries_min", {31'b0, deliveries > 100}, 32'd1);
    drive_idle();
  endtask

endmodule
